seg7_scan_decoder: RTL and testbench

- Observes a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and reconstructs the hex value shown on each digit.
- Input must be stable for a programmable dwell before capture, which rejects ghosting at scan transitions.
- Used as the read-back/monitor end of the team's display path: board self-test, and bus-level checking of display drivers.

---
 rtl/seg7_scan_decoder.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed active-low 7-segment bus monitor and hex decoder
//
// Purpose: watches a scanned 7-segment display bus and rebuilds the hex
// nibble shown on each digit. Inputs must hold for STABLE_CYCLES samples
// before they are captured, so ghosting at scan transitions is ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   seg_n[6:0]   segment lines, active-low, bit6=a .. bit0=g
//   an_n[D-1:0]  anode enables, active-low, bit i selects digit i
//   dout         decoded nibbles, dout[4i+3:4i] = digit i
//   digit_valid  bit i set while digit i holds a legal decoded value
//   upd          one-cycle pulse on a legal capture
//   upd_idx      digit index of the capture, meaningful while upd=1
//   err          one-cycle pulse on an illegal pattern or anode vector

module seg7_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 16,
   parameter int IDXW          = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_n,
   input  logic [DIGITS-1:0]     an_n,
   output logic [4*DIGITS-1:0]   dout,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  upd,
   output logic [IDXW-1:0]       upd_idx,
   output logic                  err
);

   localparam int              CNTW     = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNTW-1:0] STABLE_C = CNTW'(STABLE_CYCLES);

   logic [DIGITS-1:0]   r_an;
   logic [6:0]          r_seg;
   logic [CNTW-1:0]     r_cnt;
   logic                r_cap;
   logic [4*DIGITS-1:0] r_dout;
   logic [DIGITS-1:0]   r_valid;
   logic                r_upd;
   logic [IDXW-1:0]     r_idx;
   logic                r_err;

   logic                w_change;
   logic                w_fire;
   logic [DIGITS-1:0]   w_sel;
   logic                w_off;
   logic                w_multi;
   logic                w_hit;
   logic                w_blank;
   logic [3:0]          w_val;
   logic [IDXW-1:0]     w_idx;

   assign w_change = ({an_n, seg_n} != {r_an, r_seg});
   // Fires exactly once per dwell: r_cap is only cleared by a new value.
   assign w_fire   = (r_cnt == STABLE_C) && !r_cap;
   assign w_sel    = ~r_an;
   assign w_off    = (w_sel == '0);
   // Clearing the lowest set bit leaves something only if two or more are set.
   assign w_multi  = ((w_sel & (w_sel - DIGITS'(1))) != '0);
   assign w_blank  = (r_seg == 7'b1111111);

   always_comb begin
      w_hit = 1'b1;
      w_val = 4'h0;
      case (r_seg)
         7'b0000001: w_val = 4'h0;
         7'b1001111: w_val = 4'h1;
         7'b0010010: w_val = 4'h2;
         7'b0000110: w_val = 4'h3;
         7'b1001100: w_val = 4'h4;
         7'b0100100: w_val = 4'h5;
         7'b0100000: w_val = 4'h6;
         7'b0001111: w_val = 4'h7;
         7'b0000000: w_val = 4'h8;
         7'b0000100: w_val = 4'h9;
         7'b0001000: w_val = 4'hA;
         7'b1100000: w_val = 4'hB;
         7'b0110001: w_val = 4'hC;
         7'b1000010: w_val = 4'hD;
         7'b0110000: w_val = 4'hE;
         7'b0111000: w_val = 4'hF;
         default:    w_hit = 1'b0;
      endcase
   end

   // Only consulted when exactly one anode is active.
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_sel[i]) begin
            w_idx = IDXW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_an    <= '1;
         r_seg   <= '1;
         r_cnt   <= '0;
         r_cap   <= 1'b0;
         r_dout  <= '0;
         r_valid <= '0;
         r_upd   <= 1'b0;
         r_idx   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_upd <= 1'b0;
         r_err <= 1'b0;

         if (w_change) begin
            r_an  <= an_n;
            r_seg <= seg_n;
            r_cnt <= CNTW'(1);
            r_cap <= 1'b0;
         end else begin
            if (r_cnt != STABLE_C) begin
               r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_fire) begin
               r_cap <= 1'b1;
            end
         end

         // Capture works from the registered sample, so a change arriving on
         // the capture edge itself does not cancel a completed dwell.
         if (w_fire && !w_off) begin
            if (w_multi) begin
               r_err <= 1'b1;
            end else if (w_hit) begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (w_sel[i]) begin
                     r_dout[4*i +: 4] <= w_val;
                     r_valid[i]       <= 1'b1;
                  end
               end
               r_upd <= 1'b1;
               r_idx <= w_idx;
            end else begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (w_sel[i]) begin
                     r_valid[i] <= 1'b0;
                  end
               end
               if (!w_blank) begin
                  r_err <= 1'b1;
               end
            end
         end
      end
   end

   assign dout        = r_dout;
   assign digit_valid = r_valid;
   assign upd         = r_upd;
   assign upd_idx     = r_idx;
   assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder

module tb_seg7_scan_decoder;

   localparam int S = 4;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] dout;
   logic [3:0]  digit_valid;
   logic        upd;
   logic [1:0]  upd_idx;
   logic        err;

   seg7_scan_decoder #(
      .DIGITS        (4),
      .STABLE_CYCLES (S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .dout        (dout),
      .digit_valid (digit_valid),
      .upd         (upd),
      .upd_idx     (upd_idx),
      .err         (err)
   );

   typedef struct {
      logic [1:0]  kind;   // 1 = upd, 2 = err
      logic [1:0]  idx;
      logic [15:0] dout;
      logic [3:0]  valid;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive a vector and hold it n cycles; kind!=0 queues the expected event,
   // which becomes visible S+1 edges after the drive point.
   task automatic apply(input logic [3:0] an, input logic [6:0] seg, input int n,
                        input logic [1:0] kind, input logic [1:0] idx,
                        input logic [15:0] ed, input logic [3:0] ev);
      exp_t e;
      an_n  = an;
      seg_n = seg;
      if (kind != 2'd0) begin
         e.kind  = kind;
         e.idx   = idx;
         e.dout  = ed;
         e.valid = ev;
         e.cyc   = cyc + 1 + S;
         q.push_back(e);
      end
      tick(n);
   endtask

   always @(negedge clk) begin
      if (!rst && (upd || err)) begin
         chk("upd_err_exclusive", {31'd0, upd & err}, 32'd0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: upd=%b err=%b idx=%0d at cycle %0d, none expected",
                     upd, err, upd_idx, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("event_kind",  {30'd0, err, upd}, {30'd0, e.kind});
            chk("event_cycle", cyc, e.cyc);
            chk("event_dout",  {16'd0, dout}, {16'd0, e.dout});
            chk("event_valid", {28'd0, digit_valid}, {28'd0, e.valid});
            if (e.kind == 2'd1) begin
               chk("event_idx", {30'd0, upd_idx}, {30'd0, e.idx});
            end
         end
      end
   end

   initial begin
      rst   = 1'b1;
      an_n  = 4'b0110;
      seg_n = 7'b0101010;
      tick(2);
      an_n  = 4'b1111;
      seg_n = 7'b1111111;
      rst   = 1'b0;
      tick(1);
      chk("reset_dout",  {16'd0, dout}, 32'd0);
      chk("reset_valid", {28'd0, digit_valid}, 32'd0);
      chk("reset_upd",   {31'd0, upd}, 32'd0);
      chk("reset_err",   {31'd0, err}, 32'd0);
      chk("reset_idx",   {30'd0, upd_idx}, 32'd0);
      tick(8);

      // long hold on digit 0: one capture only
      apply(4'b1110, 7'b0010010, 10, 2'd1, 2'd0, 16'h0002, 4'b0001);

      // dwell one short of S: nothing captured
      apply(4'b1101, 7'b0001000, 3, 2'd0, 2'd0, 16'h0, 4'h0);
      chk("short_dwell_dout",  {16'd0, dout}, 32'h0002);
      chk("short_dwell_valid", {28'd0, digit_valid}, 32'b0001);

      // full scan 1, A, E, F
      apply(4'b1110, 7'b1001111, 8, 2'd1, 2'd0, 16'h0001, 4'b0001);
      apply(4'b1101, 7'b0001000, 8, 2'd1, 2'd1, 16'h00A1, 4'b0011);
      apply(4'b1011, 7'b0110000, 8, 2'd1, 2'd2, 16'h0EA1, 4'b0111);
      apply(4'b0111, 7'b0111000, 8, 2'd1, 2'd3, 16'hFEA1, 4'b1111);
      chk("scan_dout",  {16'd0, dout}, 32'hFEA1);
      chk("scan_valid", {28'd0, digit_valid}, 32'b1111);

      // illegal pattern on digit 2, then blank on digit 1
      apply(4'b1011, 7'b1111110, 8, 2'd2, 2'd0, 16'hFEA1, 4'b1011);
      apply(4'b1101, 7'b1111111, 8, 2'd0, 2'd0, 16'h0, 4'h0);
      chk("blank_valid", {28'd0, digit_valid}, 32'b1001);
      chk("blank_dout",  {16'd0, dout}, 32'hFEA1);

      // two anodes low
      apply(4'b1100, 7'b0000000, 8, 2'd2, 2'd0, 16'hFEA1, 4'b1001);

      // short hold, then reset mid-dwell with input still held
      apply(4'b0111, 7'b0000000, 2, 2'd0, 2'd0, 16'h0, 4'h0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midreset_dout",  {16'd0, dout}, 32'd0);
      chk("midreset_valid", {28'd0, digit_valid}, 32'd0);
      chk("midreset_upd",   {31'd0, upd}, 32'd0);
      begin
         exp_t e;
         e.kind  = 2'd1;
         e.idx   = 2'd3;
         e.dout  = 16'h8000;
         e.valid = 4'b1000;
         e.cyc   = cyc + 1 + S;
         q.push_back(e);
      end
      tick(10);
      chk("final_dout", {16'd0, dout}, 32'h8000);

      an_n  = 4'b1111;
      seg_n = 7'b1111111;
      tick(10);
      chk("pending_events", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
